// File: rtl/ir_queue_pkg.sv
// ir_queue_pkg: MIPS opcode/function codes, decoded field struct and decode helpers.
package ir_queue_pkg;
   typedef enum logic [5:0] {
      OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
      OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
      OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
      OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
      OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24,
      OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B,
      OP_INVALID = 6'h3F
   } opcode_t;

   typedef enum logic [5:0] {
      FUNC_SLL  = 6'h00, FUNC_SRL  = 6'h02, FUNC_SRA  = 6'h03, FUNC_SLLV = 6'h04,
      FUNC_SRLV = 6'h06, FUNC_SRAV = 6'h07, FUNC_JR   = 6'h08, FUNC_JALR = 6'h09,
      FUNC_ADD  = 6'h20, FUNC_ADDU = 6'h21, FUNC_SUB  = 6'h22, FUNC_SUBU = 6'h23,
      FUNC_AND  = 6'h24, FUNC_OR   = 6'h25, FUNC_XOR  = 6'h26, FUNC_NOR  = 6'h27,
      FUNC_SLT  = 6'h2A, FUNC_SLTU = 6'h2B, FUNC_INVALID = 6'h3F
   } func_t;

   typedef struct packed {
      opcode_t     opcode;
      func_t       funct;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shift;
      logic [15:0] imm;
      logic [25:0] target;
   } instr_fields_t;

   function automatic opcode_t logic_to_opcode(input logic [5:0] v);
      case (v)
         OP_SPECIAL, OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return opcode_t'(v);
         default: return OP_INVALID;
      endcase
   endfunction

   function automatic func_t logic_to_func(input logic [5:0] v);
      case (v)
         FUNC_SLL, FUNC_SRL, FUNC_SRA, FUNC_SLLV, FUNC_SRLV, FUNC_SRAV, FUNC_JR,
         FUNC_JALR, FUNC_ADD, FUNC_ADDU, FUNC_SUB, FUNC_SUBU, FUNC_AND, FUNC_OR,
         FUNC_XOR, FUNC_NOR, FUNC_SLT, FUNC_SLTU: return func_t'(v);
         default: return FUNC_INVALID;
      endcase
   endfunction
endpackage

// File: rtl/ir_queue_if.sv
// ir_queue_if: fetch-side push, consumer-side pop and decoded head view of the instruction queue.
interface ir_queue_if #(parameter int DEPTH = 4);
   import ir_queue_pkg::*;
   localparam int CW = $clog2(DEPTH + 1);
   logic          flush_i;
   logic [31:0]   instr_i;
   logic          valid_i;
   logic          ready_o;
   logic          valid_o;
   logic          ready_i;
   opcode_t       opcode_o;
   func_t         funct_o;
   logic [4:0]    rs_o;
   logic [4:0]    rt_o;
   logic [4:0]    rd_o;
   logic [4:0]    shift_o;
   logic [15:0]   immediate_o;
   logic [25:0]   target_o;
   logic [31:0]   instr_o;
   logic [CW-1:0] count_o;

   modport slave (
      input  flush_i, instr_i, valid_i, ready_i,
      output ready_o, valid_o, opcode_o, funct_o, rs_o, rt_o, rd_o, shift_o,
             immediate_o, target_o, instr_o, count_o
   );

   modport master (
      output flush_i, instr_i, valid_i, ready_i,
      input  ready_o, valid_o, opcode_o, funct_o, rs_o, rt_o, rd_o, shift_o,
             immediate_o, target_o, instr_o, count_o
   );
endinterface

// File: rtl/ir_decode.sv
// ir_decode: combinational split of a 32-bit MIPS word into its decoded fields.
module ir_decode
   import ir_queue_pkg::*;
(
   input  logic [31:0]   word,
   output instr_fields_t f
);
   always_comb begin
      f.opcode = logic_to_opcode(word[31:26]);
      f.funct  = logic_to_func(word[5:0]);
      f.rs     = word[25:21];
      f.rt     = word[20:16];
      f.rd     = word[15:11];
      f.shift  = word[10:6];
      f.imm    = word[15:0];
      f.target = word[25:0];
   end
endmodule

// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry instruction FIFO with flush, optional empty-queue bypass
// and a decoded view of the head word.
module ir_queue
   import ir_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int BYPASS = 1
) (
   input logic        clk,
   input logic        reset_i,
   ir_queue_if.slave  q
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam bit BP = (BYPASS != 0);

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          empty, full, push, pop, through, write, read;
   logic [31:0]   head;
   instr_fields_t fields;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign q.ready_o = ~full & ~q.flush_i;
   assign q.valid_o = ~q.flush_i & (~empty | (BP & q.valid_i));
   assign push    = q.valid_i & q.ready_o;
   assign pop     = q.valid_o & q.ready_i;
   // an empty-queue push that is popped at once never touches storage
   assign through = empty & push & pop;
   assign write   = push & ~through;
   assign read    = pop & ~empty;
   assign head    = ~empty ? mem[rd_ptr] : BP ? q.instr_i : 32'h0;

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (q.flush_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= write ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr <= read ? rd_ptr + AW'(1) : rd_ptr;
         count  <= count + CW'(write) - CW'(read);
      end
   end

   always_ff @(posedge clk) begin
      if (write) mem[wr_ptr] <= q.instr_i;
   end

   ir_decode u_decode (.word(head), .f(fields));

   assign q.instr_o     = head;
   assign q.opcode_o    = fields.opcode;
   assign q.funct_o     = fields.funct;
   assign q.rs_o        = fields.rs;
   assign q.rt_o        = fields.rt;
   assign q.rd_o        = fields.rd;
   assign q.shift_o     = fields.shift;
   assign q.immediate_o = fields.imm;
   assign q.target_o    = fields.target;
   assign q.count_o     = count;
endmodule
